// File: rtl/impulse_pkg.sv
// impulse_pkg: shared widths and FSM encodings for the impulse
// generator and its feeder.
package impulse_pkg;

    localparam int BW = 8;

    typedef logic [BW-1:0] byte_t;

    typedef enum logic {
        I_WAIT = 1'b0,
        I_ACK  = 1'b1
    } in_state_e;

    typedef enum logic [1:0] {
        O_IDLE = 2'd0,
        O_LOAD = 2'd1,
        O_DAV  = 2'd2
    } out_state_e;

endpackage

// File: rtl/impulse_feeder_if.sv
// impulse_feeder_if: source-side and generator-side /dav-rfd
// handshakes of the feeder; master is the feeder itself.
interface impulse_feeder_if;
    import impulse_pkg::*;

    byte_t data_in;
    logic  dav_in_;
    logic  rfd_in;
    byte_t numero;
    logic  dav_;
    logic  rfd;

    modport master (
        input  data_in, dav_in_, rfd,
        output rfd_in, numero, dav_
    );

    modport slave (
        output data_in, dav_in_, rfd,
        input  rfd_in, numero, dav_
    );

endinterface

// File: rtl/impulse_feeder_fifo.sv
// byte_fifo: small power-of-two byte FIFO with registered flags;
// full_nxt_o exposes the post-edge full flag to the producer FSM.
module byte_fifo
    import impulse_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic  clock,
    input  logic  reset_,
    input  logic  push_i,
    input  logic  pop_i,
    input  byte_t din_i,
    output byte_t head_o,
    output logic  full_o,
    output logic  empty_o,
    output logic  full_nxt_o
);

    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    byte_t         mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          do_push, do_pop;

    // Guards live here so no caller can over- or under-run the buffer.
    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (do_push && !do_pop)      cnt_d = cnt_q + CNT_ONE;
        else if (do_pop && !do_push) cnt_d = cnt_q - CNT_ONE;
        full_d  = (cnt_d == FULL_CNT);
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign head_o     = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign full_nxt_o = full_d;

endmodule

// File: rtl/impulse_feeder.sv
// impulse_feeder: buffers pulse lengths between a bursty source and the
// generator. IMPULSE_FEEDER_DROP_ZERO_EN: accept but discard zero lengths.
module impulse_feeder
    import impulse_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              clock,
    input  logic              reset_,
    impulse_feeder_if.master  bus,
    output logic              empty,
    output logic              full
);

    in_state_e  in_q, in_d;
    out_state_e out_q, out_d;

    logic  rfd_in_q, rfd_in_d;
    logic  dav_q, dav_d;
    byte_t numero_q, numero_d;

    logic  accept, push, pop;
    logic  f_full, f_empty, f_full_nxt;
    byte_t head;

    assign accept = (in_q == I_WAIT) && !bus.dav_in_ && !f_full;
    assign pop    = (out_q == O_IDLE) && !f_empty && bus.rfd;

`ifdef IMPULSE_FEEDER_DROP_ZERO_EN
    assign push = accept && (bus.data_in != '0);
`else
    assign push = accept;
`endif

    byte_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clock      (clock),
        .reset_     (reset_),
        .push_i     (push),
        .pop_i      (pop),
        .din_i      (bus.data_in),
        .head_o     (head),
        .full_o     (f_full),
        .empty_o    (f_empty),
        .full_nxt_o (f_full_nxt)
    );

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            in_q  <= I_WAIT;
            out_q <= O_IDLE;
        end else begin
            in_q  <= in_d;
            out_q <= out_d;
        end
    end

    always_comb begin
        in_d = in_q;
        unique case (in_q)
            I_WAIT: if (accept) in_d = I_ACK;
            I_ACK:  if (bus.dav_in_) in_d = I_WAIT;
            default: in_d = I_WAIT;
        endcase
        out_d = out_q;
        unique case (out_q)
            O_IDLE: if (pop) out_d = O_LOAD;
            O_LOAD: out_d = O_DAV;
            O_DAV:  if (!bus.rfd) out_d = O_IDLE;
            default: out_d = O_IDLE;
        endcase
    end

    // rfd_in tracks the post-edge full flag so it rises with the freeing pop.
    always_comb begin
        rfd_in_d = 1'b0;
        dav_d    = dav_q;
        numero_d = numero_q;
        unique case (in_q)
            I_WAIT: rfd_in_d = !accept && !f_full_nxt;
            I_ACK:  rfd_in_d = bus.dav_in_ && !f_full_nxt;
            default: rfd_in_d = 1'b0;
        endcase
        unique case (out_q)
            O_IDLE: begin
                dav_d = 1'b1;
                if (pop) numero_d = head;
            end
            O_LOAD: dav_d = 1'b0;
            O_DAV:  if (!bus.rfd) dav_d = 1'b1;
            default: dav_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            rfd_in_q <= 1'b1;
            dav_q    <= 1'b1;
            numero_q <= '0;
        end else begin
            rfd_in_q <= rfd_in_d;
            dav_q    <= dav_d;
            numero_q <= numero_d;
        end
    end

    assign bus.rfd_in = rfd_in_q;
    assign bus.dav_   = dav_q;
    assign bus.numero = numero_q;
    assign empty      = f_empty;
    assign full       = f_full;

endmodule

// File: tb/tb_impulse_feeder.sv
// tb_impulse_feeder: directed vector tables plus handshake sequences
// against a small generator model.
module tb_impulse_feeder;
    import impulse_pkg::*;

    logic clock  = 1'b0;
    logic reset_ = 1'b0;
    logic empty, full;

    impulse_feeder_if ifc();

    impulse_feeder #(
        .DEPTH (4),
        .AW    (2)
    ) dut (
        .clock  (clock),
        .reset_ (reset_),
        .bus    (ifc),
        .empty  (empty),
        .full   (full)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    logic gen_auto = 1'b0;
    logic gen_rfd  = 1'b1;
    logic tab_rfd  = 1'b1;
    assign ifc.rfd = gen_auto ? gen_rfd : tab_rfd;

    // Generator model: latch numero on dav_ low, stay busy for the pulse.
    logic [1:0] g_st  = 2'd0;
    logic [8:0] g_cnt = 9'd0;
    byte_t      got[$];

    always @(posedge clock) begin
        if (!gen_auto) begin
            g_st    <= 2'd0;
            gen_rfd <= 1'b1;
        end else begin
            case (g_st)
                2'd0: if (ifc.dav_ === 1'b0) begin
                    got.push_back(ifc.numero);
                    g_cnt   <= (ifc.numero == 8'd0) ? 9'd256 : {1'b0, ifc.numero};
                    gen_rfd <= 1'b0;
                    g_st    <= 2'd1;
                end
                2'd1: if (g_cnt <= 9'd1) g_st <= 2'd2;
                      else g_cnt <= g_cnt - 9'd1;
                2'd2: if (ifc.dav_ === 1'b1) begin
                    gen_rfd <= 1'b1;
                    g_st    <= 2'd0;
                end
                default: g_st <= 2'd0;
            endcase
        end
    end

    typedef struct {
        logic  dav_in_;
        byte_t din;
        logic  rfd;
        logic  e_rfd_in;
        logic  e_dav;
        byte_t e_num;
        logic  e_empty;
        logic  e_full;
    } vec_t;

    vec_t t1[7];
    vec_t t2[16];
    byte_t burst[6];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(string nm, logic r, logic d, byte_t n,
                            logic e, logic f);
        chk({nm, ".rfd_in"}, int'(ifc.rfd_in), int'(r));
        chk({nm, ".dav_"},   int'(ifc.dav_),   int'(d));
        chk({nm, ".numero"}, int'(ifc.numero), int'(n));
        chk({nm, ".empty"},  int'(empty),      int'(e));
        chk({nm, ".full"},   int'(full),       int'(f));
    endtask

    task automatic apply(string nm, vec_t v);
        ifc.dav_in_ = v.dav_in_;
        ifc.data_in = v.din;
        tab_rfd     = v.rfd;
        tick();
        chk_outs(nm, v.e_rfd_in, v.e_dav, v.e_num, v.e_empty, v.e_full);
    endtask

    task automatic send(byte_t v);
        int b;
        b = 0;
        ifc.data_in = v;
        ifc.dav_in_ = 1'b0;
        while (ifc.rfd_in !== 1'b1 && b < 400) begin
            tick();
            b++;
        end
        chk($sformatf("send_rdy_%0h", v), int'(ifc.rfd_in), 1);
        tick();
        chk($sformatf("send_ack_%0h", v), int'(ifc.rfd_in), 0);
        ifc.dav_in_ = 1'b1;
        tick();
    endtask

    task automatic wait_got(int n, int budget);
        int b;
        b = 0;
        while (got.size() < n && b < budget) begin
            tick();
            b++;
        end
        chk("wait_got", got.size(), n);
    endtask

    initial begin
        int base;

        t1[0] = '{1'b0, 8'h05, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        t1[1] = '{1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 8'h05, 1'b1, 1'b0};
        t1[2] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h05, 1'b1, 1'b0};
        t1[3] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h05, 1'b1, 1'b0};
        t1[4] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h05, 1'b1, 1'b0};
        t1[5] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h05, 1'b1, 1'b0};
        t1[6] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h05, 1'b1, 1'b0};

        t2[0]  = '{1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 8'h09, 1'b0, 1'b0};
        t2[1]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h09, 1'b0, 1'b0};
        t2[2]  = '{1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 8'h09, 1'b0, 1'b0};
        t2[3]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h09, 1'b0, 1'b0};
        t2[4]  = '{1'b0, 8'h33, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
        t2[5]  = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0};
        t2[6]  = '{1'b0, 8'h44, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
        t2[7]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0};
        t2[8]  = '{1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1};
        t2[9]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1};
        t2[10] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0};
        t2[11] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0};
        t2[12] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0};
        t2[13] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0};
        t2[14] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0};
        t2[15] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0};

        burst = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9};

        ifc.dav_in_ = 1'b1;
        ifc.data_in = 8'h00;
        repeat (2) @(negedge clock);
        chk_outs("reset", 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
        reset_ = 1'b1;

        // Single transfer of 5 with manual generator handshake.
        for (int i = 0; i < 7; i++) apply($sformatf("t1[%0d]", i), t1[i]);

        // Burst of 6 into a 4-deep FIFO with the generator busy.
        tab_rfd = 1'b0;
        base = got.size();
        for (int i = 0; i < 4; i++) send(burst[i]);
        chk("burst.full", int'(full), 1);
        chk("burst.rfd_in", int'(ifc.rfd_in), 0);
        fork
            begin
                send(burst[4]);
                send(burst[5]);
            end
            begin
                repeat (3) begin
                    tick();
                    chk("stall.full", int'(full), 1);
                    chk("stall.rfd_in", int'(ifc.rfd_in), 0);
                end
                gen_auto = 1'b1;
            end
        join
        wait_got(base + 6, 800);
        for (int i = 0; i < 6; i++)
            chk($sformatf("burst.got[%0d]", i), int'(got[base + i]), int'(burst[i]));
        repeat (3) tick();
        gen_auto = 1'b0;
        chk("burst.drained", int'(empty), 1);
        chk("burst.dav_", int'(ifc.dav_), 1);

        // Push+pop at occupancy 2 with pointers wrapping.
        for (int i = 0; i < 16; i++) apply($sformatf("t2[%0d]", i), t2[i]);
        base = got.size();
        gen_auto = 1'b1;
        wait_got(base + 2, 400);
        chk("wrap.got0", int'(got[base]), 8'h44);
        chk("wrap.got1", int'(got[base + 1]), 8'h55);
        repeat (4) tick();
        chk("wrap.empty", int'(empty), 1);

        // Zero length followed by 7.
        base = got.size();
        send(8'h00);
        send(8'h07);
`ifdef IMPULSE_FEEDER_DROP_ZERO_EN
        wait_got(base + 1, 400);
        chk("zero.got0", int'(got[base]), 8'h07);
        repeat (20) tick();
        chk("zero.count", got.size(), base + 1);
`else
        wait_got(base + 2, 900);
        chk("zero.got0", int'(got[base]), 8'h00);
        chk("zero.got1", int'(got[base + 1]), 8'h07);
`endif

        // Idle generator with empty FIFO: nothing moves.
        repeat (20) tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle.dav_", int'(ifc.dav_), 1);
            chk("idle.numero", int'(ifc.numero), 8'h07);
        end

        // Asynchronous reset while dav_ is low and 2 entries are buffered.
        gen_auto = 1'b0;
        tab_rfd  = 1'b1;
        tick();
        send(8'h21);
        send(8'h22);
        send(8'h23);
        chk("pre_rst.dav_", int'(ifc.dav_), 0);
        chk("pre_rst.empty", int'(empty), 0);
        #2 reset_ = 1'b0;
        #1;
        chk_outs("async_rst", 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset_ = 1'b1;
        base = got.size();
        gen_auto = 1'b1;
        repeat (40) tick();
        chk("post_rst.count", got.size(), base);
        chk("post_rst.dav_", int'(ifc.dav_), 1);
        chk("post_rst.empty", int'(empty), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
